// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_pkg
// Description : Shared types and constants for the accumulator unit:
//               FSM state encoding and the nibble-to-7-segment table.
// Revision    : 1.0 - initial release
// ============================================================================
package accum_pkg;

    // Accumulate sequencer: wait for Run, add once, wait for Run release.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Active-low segments ordered gfedcba; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] c_SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage : accum_pkg
`default_nettype wire

// File: rtl/accum_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : accum_unit_if
// Description : Board-facing signal bundle of the accumulator unit.
//               slave  : accumulator side (SW/Run/Clear/Sub in, Sum/Ovf/LED/HEX out)
//               master : stimulus side (mirror image)
// Revision    : 1.0 - initial release
// ============================================================================
interface accum_unit_if #(
    parameter int IN_W  = 10,
    parameter int ACC_W = 17
);
    logic [IN_W-1:0]  SW;
    logic             Run;
    logic             Clear;
    logic             Sub;
    logic [ACC_W-1:0] Sum;
    logic             Ovf;
    logic [9:0]       LED;
    logic [6:0]       HEX0;
    logic [6:0]       HEX1;
    logic [6:0]       HEX2;
    logic [6:0]       HEX3;
    logic [6:0]       HEX4;
    logic [6:0]       HEX5;

    modport master (
        output SW, Run, Clear, Sub,
        input  Sum, Ovf, LED, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  SW, Run, Clear, Sub,
        output Sum, Ovf, LED, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface : accum_unit_if
`default_nettype wire

// File: rtl/hex_driver.sv
`default_nettype none
// ============================================================================
// Module      : hex_driver
// Description : Converts one 4-bit nibble to active-low 7-segment (gfedcba).
// Ports       : i_nibble [3:0] - value to display
//               o_seg    [6:0] - active-low segment drive
// Revision    : 1.0 - initial release
// ============================================================================
module hex_driver
    import accum_pkg::*;
(
    input  wire logic [3:0] i_nibble,
    output logic      [6:0] o_seg
);

    assign o_seg = c_SEG_TABLE[i_nibble];

endmodule : hex_driver
`default_nettype wire

// File: rtl/accum_unit.sv
`default_nettype none
// ============================================================================
// Module      : accum_unit
// Description : Push-button accumulator. Each Run press adds (or subtracts)
//               SW to Sum exactly once; Ovf is a sticky carry/borrow flag.
//               Sum is shown on six hex displays, Ovf and SW on the LEDs.
// Ports       : Clk     - system clock, rising edge
//               Reset_n - asynchronous active-low reset
//               bus     - accum_unit_if.slave (SW, Run, Clear, Sub in;
//                         Sum, Ovf, LED, HEX0..HEX5 out)
// Config      : `define ACCUM_SAT_EN to clamp Sum on overflow/underflow
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module accum_unit
    import accum_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int ACC_W = 17
) (
    input  wire logic     Clk,
    input  wire logic     Reset_n,
    accum_unit_if.slave   bus
);

    logic             r_run_meta;
    logic             r_run_sync;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_sum;
    logic [ACC_W-1:0] w_sum_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic [ACC_W-1:0] w_sw_ext;
    logic [ACC_W:0]   w_add_full;
    logic [ACC_W:0]   w_sub_full;
    logic [23:0]      w_sum24;
    logic [5:0][6:0]  w_hex;

    // Run comes from a button and is asynchronous to Clk.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_run_meta <= 1'b0;
            r_run_sync <= 1'b0;
        end else begin
            r_run_meta <= bus.Run;
            r_run_sync <= r_run_meta;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear never alters the sequencing; only the datapath sees it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_run_sync)  w_state_nxt = ADD;
            ADD:                      w_state_nxt = HOLD;
            HOLD:    if (!r_run_sync) w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // One extra bit on each operation exposes carry (add) or borrow (sub).
    assign w_sw_ext   = ACC_W'(bus.SW);
    assign w_add_full = {1'b0, r_sum} + {1'b0, w_sw_ext};
    assign w_sub_full = {1'b0, r_sum} - {1'b0, w_sw_ext};

    always_comb begin
        w_sum_nxt = r_sum;
        w_ovf_nxt = r_ovf;
        if (bus.Clear) begin
            w_sum_nxt = '0;
            w_ovf_nxt = 1'b0;
        end else if (r_state == ADD) begin
            if (bus.Sub) begin
`ifdef ACCUM_SAT_EN
                w_sum_nxt = w_sub_full[ACC_W] ? '0 : w_sub_full[ACC_W-1:0];
`else
                w_sum_nxt = w_sub_full[ACC_W-1:0];
`endif
                w_ovf_nxt = r_ovf | w_sub_full[ACC_W];
            end else begin
`ifdef ACCUM_SAT_EN
                w_sum_nxt = w_add_full[ACC_W] ? '1 : w_add_full[ACC_W-1:0];
`else
                w_sum_nxt = w_add_full[ACC_W-1:0];
`endif
                w_ovf_nxt = r_ovf | w_add_full[ACC_W];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_sum <= w_sum_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    // Display: Sum is zero-extended so all six digits are always defined.
    assign w_sum24 = 24'(r_sum);

    for (genvar gi = 0; gi < 6; gi++) begin : g_hex
        hex_driver u_hex (
            .i_nibble (w_sum24[gi*4 +: 4]),
            .o_seg    (w_hex[gi])
        );
    end

    assign bus.Sum  = r_sum;
    assign bus.Ovf  = r_ovf;
    assign bus.LED  = {r_ovf, 9'(bus.SW)};
    assign bus.HEX0 = w_hex[0];
    assign bus.HEX1 = w_hex[1];
    assign bus.HEX2 = w_hex[2];
    assign bus.HEX3 = w_hex[3];
    assign bus.HEX4 = w_hex[4];
    assign bus.HEX5 = w_hex[5];

endmodule : accum_unit
`default_nettype wire

// File: tb/tb_accum_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_unit
// Description : Directed self-checking bench for accum_unit. Two instances
//               share one stimulus: a 17-bit accumulator and a 10-bit one
//               used for the wrap/clamp boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_unit;
    import accum_pkg::*;

`ifdef ACCUM_SAT_EN
    localparam logic [31:0] c_EXP_WRAP10 = 32'd1023;
    localparam logic [31:0] c_EXP_SUB17  = 32'd0;
    localparam logic [31:0] c_EXP_SUB10  = 32'd0;
`else
    localparam logic [31:0] c_EXP_WRAP10 = 32'd1022;
    localparam logic [31:0] c_EXP_SUB17  = 32'h1FFFE;
    localparam logic [31:0] c_EXP_SUB10  = 32'h3FE;
`endif

    logic       clk;
    logic       rst_n;
    logic [9:0] sw;
    logic       run;
    logic       clear;
    logic       sub;
    int         n_checks;
    int         n_errors;

    accum_unit_if #(.IN_W(10), .ACC_W(17)) bus17 ();
    accum_unit_if #(.IN_W(10), .ACC_W(10)) bus10 ();

    assign bus17.SW    = sw;
    assign bus17.Run   = run;
    assign bus17.Clear = clear;
    assign bus17.Sub   = sub;
    assign bus10.SW    = sw;
    assign bus10.Run   = run;
    assign bus10.Clear = clear;
    assign bus10.Sub   = sub;

    accum_unit #(.IN_W(10), .ACC_W(17)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus17.slave)
    );

    accum_unit #(.IN_W(10), .ACC_W(10)) dut10 (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus10.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full button press: hold long enough to pass ADD, then release to IDLE.
    task automatic press(input logic [9:0] v);
        sw  = v;
        run = 1'b1;
        repeat (5) @(negedge clk);
        run = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        sw    = '0;
        run   = 1'b0;
        clear = 1'b0;
        sub   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_sum",   32'(bus17.Sum),  32'd0);
        check_val("rst_ovf",   32'(bus17.Ovf),  32'd0);
        check_val("rst_hex0",  32'(bus17.HEX0), 32'b1000000);
        check_val("rst_state", 32'(dut.r_state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // 7 + 11 = 18 on both widths
        press(10'd7);
        press(10'd11);
        check_val("sum18",     32'(bus17.Sum),  32'd18);
        check_val("sum18_10",  32'(bus10.Sum),  32'd18);
        check_val("hex0_2",    32'(bus17.HEX0), 32'b0100100);
        check_val("hex1_1",    32'(bus17.HEX1), 32'b1111001);
        check_val("hex2_0",    32'(bus17.HEX2), 32'b1000000);
        check_val("hex5_0",    32'(bus17.HEX5), 32'b1000000);
        check_val("ovf18",     32'(bus17.Ovf),  32'd0);
        check_val("led18",     32'(bus17.LED),  32'd11);

        // Latency and single update while Run is held 20 cycles
        sw  = 10'd5;
        run = 1'b1;
        repeat (3) @(negedge clk);
        check_val("lat_k2",    32'(bus17.Sum), 32'd18);
        @(negedge clk);
        check_val("lat_k3",    32'(bus17.Sum), 32'd23);
        repeat (16) @(negedge clk);
        check_val("hold_once", 32'(bus17.Sum), 32'd23);
        run = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rel_once",  32'(bus17.Sum), 32'd23);

        // Clear from IDLE
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_val("clr_sum",   32'(bus17.Sum),  32'd0);
        check_val("clr_sum10", 32'(bus10.Sum),  32'd0);
        check_val("clr_state", 32'(dut.r_state), 32'(IDLE));

        // 10-bit boundary: 1023 + 1023
        press(10'd1023);
        check_val("w10_first", 32'(bus10.Sum), 32'd1023);
        check_val("w10_ovf0",  32'(bus10.Ovf), 32'd0);
        press(10'd1023);
        check_val("w10_sum",   32'(bus10.Sum), c_EXP_WRAP10);
        check_val("w10_ovf",   32'(bus10.Ovf), 32'd1);
        check_val("w10_led9",  32'(bus10.LED[9]), 32'd1);
        check_val("w17_sum",   32'(bus17.Sum), 32'd2046);
        check_val("w17_ovf",   32'(bus17.Ovf), 32'd0);

        // Subtract underflow: 5 - 7
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        press(10'd5);
        sub = 1'b1;
        press(10'd7);
        sub = 1'b0;
        check_val("sub_sum",   32'(bus17.Sum),    c_EXP_SUB17);
        check_val("sub_ovf",   32'(bus17.Ovf),    32'd1);
        check_val("sub_led9",  32'(bus17.LED[9]), 32'd1);
        check_val("sub_led_sw",32'(bus17.LED[8:0]), 32'd7);
        check_val("sub_sum10", 32'(bus10.Sum),    c_EXP_SUB10);

        // Sticky Ovf survives a later non-overflowing add
        press(10'd0);
        check_val("ovf_sticky", 32'(bus17.Ovf), 32'd1);

        // Clear during the ADD cycle wins over the add
        sw  = 10'd9;
        run = 1'b1;
        repeat (3) @(negedge clk);
        check_val("in_add",    32'(dut.r_state), 32'(ADD));
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_val("cadd_sum",  32'(bus17.Sum),   32'd0);
        check_val("cadd_ovf",  32'(bus17.Ovf),   32'd0);
        check_val("cadd_hold", 32'(dut.r_state), 32'(HOLD));
        run = 1'b0;
        repeat (5) @(negedge clk);
        check_val("cadd_rel",  32'(bus17.Sum),   32'd0);
        check_val("cadd_idle", 32'(dut.r_state), 32'(IDLE));

        // Asynchronous reset in HOLD, then one add with Run still high
        press(10'd7);
        press(10'd11);
        sw  = 10'd0;
        run = 1'b1;
        repeat (5) @(negedge clk);
        check_val("pre_hold",  32'(dut.r_state), 32'(HOLD));
        check_val("pre_sum",   32'(bus17.Sum),   32'd18);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_sum",  32'(bus17.Sum),   32'd0);
        check_val("arst_state",32'(dut.r_state), 32'(IDLE));
        sw = 10'd4;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_val("post_add",  32'(bus17.Sum),   32'd4);
        repeat (6) @(negedge clk);
        check_val("post_once", 32'(bus17.Sum),   32'd4);
        run = 1'b0;
        repeat (5) @(negedge clk);
        check_val("post_idle", 32'(dut.r_state), 32'(IDLE));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_accum_unit
`default_nettype wire
